// File: rtl/snap_pkg.sv
// Shared types and bit positions for the snapshot trigger/capture controller.
// Control-word and status-word layouts live here so that software-facing indices stay in one place.
package snap_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        OFFSET  = 3'd2,
        CAPTURE = 3'd3,
        DONE    = 3'd4
    } state_e;

    localparam int CTRL_ARM      = 0;
    localparam int CTRL_TRIG_SRC = 1;
    localparam int CTRL_WE_SRC   = 2;

    localparam int STAT_DONE     = 31;

endpackage

// File: rtl/snap_arm_edge.sv
// Registered rising-edge detector for the software arm bit.
// arm_edge is high for the one cycle in which arm_in is high and was low on the previous cycle.
module snap_arm_edge (
    input  logic clk,
    input  logic rst,
    input  logic arm_in,
    output logic arm_edge
);

    logic arm_q;
    logic arm_d;

    always_comb begin
        arm_d = arm_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            arm_q <= 1'b0;
        end else begin
            arm_q <= arm_d;
        end
    end

    assign arm_edge = arm_in & ~arm_q;

endmodule

// File: rtl/snap_trig_capture.sv
// Snapshot capture controller: arm, wait for a qualified trigger, skip trig_offset valid
// samples, then write one full buffer of samples into the snapshot BRAM.
module snap_trig_capture
    import snap_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 10,
    parameter int OFFSET_W = 32
) (
    input  logic                user_clk,
    input  logic                user_rst,
    input  logic [31:0]         ctrl_in,
    input  logic [OFFSET_W-1:0] trig_offset,
    input  logic [DATA_W-1:0]   din,
    input  logic                we,
    input  logic                trig,
    output logic [ADDR_W-1:0]   bram_addr,
    output logic [DATA_W-1:0]   bram_data,
    output logic                bram_we,
    output logic [31:0]         status_out
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'((1 << ADDR_W) - 1);

    state_e              state_q, state_d;
    logic [OFFSET_W-1:0] off_cnt_q, off_cnt_d;
    logic [CNT_W-1:0]    word_cnt_q, word_cnt_d;
    logic                done_q, done_d;
    logic                bram_we_q, bram_we_d;
    logic [ADDR_W-1:0]   bram_addr_q, bram_addr_d;
    logic [DATA_W-1:0]   bram_data_q, bram_data_d;

    logic arm_edge;
    logic valid;
    logic trig_hit;
    logic write_sample;

    logic unused_ctrl;
    assign unused_ctrl = ^ctrl_in[31:3];

    snap_arm_edge u_arm_edge (
        .clk      (user_clk),
        .rst      (user_rst),
        .arm_in   (ctrl_in[CTRL_ARM]),
        .arm_edge (arm_edge)
    );

    assign valid    = ctrl_in[CTRL_WE_SRC] | we;
    assign trig_hit = ctrl_in[CTRL_TRIG_SRC] | trig;

    always_comb begin
        state_d      = state_q;
        off_cnt_d    = off_cnt_q;
        word_cnt_d   = word_cnt_q;
        done_d       = done_q;
        bram_we_d    = 1'b0;
        bram_addr_d  = bram_addr_q;
        bram_data_d  = bram_data_q;
        write_sample = 1'b0;

        // A fresh arm edge abandons whatever capture is in flight, without writing.
        if (arm_edge) begin
            state_d     = ARMED;
            off_cnt_d   = '0;
            word_cnt_d  = '0;
            done_d      = 1'b0;
            bram_addr_d = '0;
        end else begin
            unique case (state_q)
                ARMED: begin
                    if (trig_hit && valid) begin
                        if (trig_offset == '0) begin
                            write_sample = 1'b1;
                        end else begin
                            off_cnt_d = trig_offset - OFFSET_W'(1);
                            state_d   = OFFSET;
                        end
                    end
                end
                OFFSET: begin
                    if (valid) begin
                        if (off_cnt_q == '0) begin
                            write_sample = 1'b1;
                        end else begin
                            off_cnt_d = off_cnt_q - OFFSET_W'(1);
                        end
                    end
                end
                CAPTURE: begin
                    write_sample = valid;
                end
                default: ;
            endcase
        end

        // Address is the count before increment; the final word parks the FSM in DONE.
        if (write_sample) begin
            bram_we_d   = 1'b1;
            bram_addr_d = word_cnt_q[ADDR_W-1:0];
            bram_data_d = din;
            word_cnt_d  = word_cnt_q + CNT_W'(1);
            if (word_cnt_q == LAST_WORD) begin
                state_d = DONE;
                done_d  = 1'b1;
            end else begin
                state_d = CAPTURE;
            end
        end
    end

    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            state_q     <= IDLE;
            off_cnt_q   <= '0;
            word_cnt_q  <= '0;
            done_q      <= 1'b0;
            bram_we_q   <= 1'b0;
            bram_addr_q <= '0;
            bram_data_q <= '0;
        end else begin
            state_q     <= state_d;
            off_cnt_q   <= off_cnt_d;
            word_cnt_q  <= word_cnt_d;
            done_q      <= done_d;
            bram_we_q   <= bram_we_d;
            bram_addr_q <= bram_addr_d;
            bram_data_q <= bram_data_d;
        end
    end

    assign bram_we   = bram_we_q;
    assign bram_addr = bram_addr_q;
    assign bram_data = bram_data_q;

    always_comb begin
        status_out             = '0;
        status_out[STAT_DONE]  = done_q;
        status_out[ADDR_W:0]   = word_cnt_q;
    end

endmodule

// File: tb/tb_snap_trig_capture.sv
// Bench for snap_trig_capture (ADDR_W = 4): directed scenarios plus random traffic, each cycle
// compared against a model that tracks the index of every valid sample since the trigger.
module tb_snap_trig_capture;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 4;
    localparam int OFFSET_W = 32;
    localparam int DEPTH    = 1 << ADDR_W;

    logic                user_clk = 1'b0;
    logic                user_rst;
    logic [31:0]         ctrl_in;
    logic [OFFSET_W-1:0] trig_offset;
    logic [DATA_W-1:0]   din;
    logic                we;
    logic                trig;
    logic [ADDR_W-1:0]   bram_addr;
    logic [DATA_W-1:0]   bram_data;
    logic                bram_we;
    logic [31:0]         status_out;

    snap_trig_capture #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .OFFSET_W (OFFSET_W)
    ) dut (
        .user_clk    (user_clk),
        .user_rst    (user_rst),
        .ctrl_in     (ctrl_in),
        .trig_offset (trig_offset),
        .din         (din),
        .we          (we),
        .trig        (trig),
        .bram_addr   (bram_addr),
        .bram_data   (bram_data),
        .bram_we     (bram_we),
        .status_out  (status_out)
    );

    always #5 user_clk = ~user_clk;

    int n_cmp = 0;
    int n_err = 0;
    int nwr;
    logic [31:0] first_data;

    // Reference model: k counts valid samples since the trigger (trigger sample is k = 0);
    // sample k is stored at address k - off when off <= k < off + DEPTH.
    bit      m_arm_prev;
    bit      m_armed;
    bit      m_trig;
    bit      m_done;
    longint  m_k;
    longint  m_off;
    int      m_cnt;
    bit      e_we;
    longint  e_addr;
    logic [31:0] e_data;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic take_sample();
        if (m_k >= m_off) begin
            e_we   = 1'b1;
            e_addr = m_k - m_off;
            e_data = din;
            m_cnt++;
            m_done = (m_cnt == DEPTH);
        end
        m_k++;
    endtask

    task automatic model_step();
        bit edge_now;
        bit valid;
        e_we = 1'b0;
        if (user_rst) begin
            m_arm_prev = 1'b0;
            m_armed    = 1'b0;
            m_trig     = 1'b0;
            m_done     = 1'b0;
            m_cnt      = 0;
            m_k        = 0;
            m_off      = 0;
        end else begin
            edge_now   = ctrl_in[0] && !m_arm_prev;
            m_arm_prev = ctrl_in[0];
            valid      = ctrl_in[2] || we;
            if (edge_now) begin
                m_armed = 1'b1;
                m_trig  = 1'b0;
                m_cnt   = 0;
                m_done  = 1'b0;
            end else if (m_armed && !m_trig) begin
                if ((ctrl_in[1] || trig) && valid) begin
                    m_trig = 1'b1;
                    m_off  = longint'(trig_offset);
                    m_k    = 0;
                    take_sample();
                end
            end else if (m_armed && m_trig && valid && m_cnt < DEPTH) begin
                take_sample();
            end
        end
    endtask

    task automatic tick();
        logic [31:0] e_status;
        model_step();
        @(posedge user_clk);
        #1;
        e_status = (m_done ? 32'h8000_0000 : 32'h0) | 32'(m_cnt);
        chk("bram_we", {31'b0, bram_we}, {31'b0, e_we});
        chk("status", status_out, e_status);
        if (e_we) begin
            chk("bram_addr", {28'b0, bram_addr}, 32'(e_addr));
            chk("bram_data", bram_data, e_data);
        end
        if (bram_we) begin
            if (nwr == 0) first_data = bram_data;
            nwr++;
        end
    endtask

    initial begin
        user_rst    = 1'b1;
        ctrl_in     = '0;
        trig_offset = '0;
        din         = '0;
        we          = 1'b0;
        trig        = 1'b0;
        nwr         = 0;
        first_data  = '0;

        // Reset with toggling data
        for (int i = 0; i < 3; i++) begin
            din = (i % 2 == 0) ? 32'hFFFF_FFFF : 32'h0;
            tick();
        end
        user_rst = 1'b0;
        din = '0;
        tick();

        // Immediate capture, offset 0, data = running counter
        ctrl_in = 32'h6;
        tick();
        ctrl_in = 32'h7;
        nwr = 0;
        for (int i = 0; i < 25; i++) begin
            din = 32'(i);
            tick();
        end
        chk("imm_nwr", nwr, 16);
        chk("imm_status", status_out, 32'h8000_0010);

        // External trigger with offset 5, retrigger and offset change during OFFSET
        ctrl_in = 32'h0;
        we = 1'b1;
        tick();
        ctrl_in = 32'h1;
        din = 32'd90;
        tick();
        tick();
        nwr = 0;
        din = 32'd100;
        trig = 1'b1;
        trig_offset = 32'd5;
        tick();
        trig = 1'b0;
        for (int i = 0; i < 25; i++) begin
            din = din + 1;
            if (i == 1) begin
                trig = 1'b1;
                trig_offset = 32'd50;
            end else begin
                trig = 1'b0;
            end
            tick();
        end
        chk("off_first", first_data, 32'd105);
        chk("off_nwr", nwr, 16);

        // Gated valid: we on every other cycle, offset 2
        ctrl_in = 32'h2;
        trig_offset = 32'd2;
        we = 1'b0;
        tick();
        ctrl_in = 32'h3;
        tick();
        nwr = 0;
        for (int i = 0; i < 45; i++) begin
            we  = (i % 2 == 0);
            din = 32'h1000 + 32'(i);
            tick();
        end
        chk("gate_nwr", nwr, 16);
        chk("gate_status", status_out, 32'h8000_0010);

        // Re-arm after 7 words
        ctrl_in = 32'h6;
        trig_offset = 32'd0;
        tick();
        ctrl_in = 32'h7;
        nwr = 0;
        for (int i = 0; i < 20 && nwr < 7; i++) begin
            din = 32'h2000 + 32'(i);
            tick();
        end
        chk("rearm_pre", nwr, 7);
        ctrl_in = 32'h6;
        tick();
        ctrl_in = 32'h5;
        tick();
        chk("rearm_status", status_out, 32'h0);
        nwr = 0;
        for (int i = 0; i < 3; i++) tick();
        chk("rearm_idle", nwr, 0);
        trig = 1'b1;
        din = 32'hABCD;
        tick();
        trig = 1'b0;
        chk("rearm_addr0", {31'b0, bram_we} | ({28'b0, bram_addr} << 1), 32'h1);
        for (int i = 0; i < 20; i++) tick();

        // Trigger before arm, then reset mid-capture
        user_rst = 1'b1;
        ctrl_in = 32'h0;
        tick();
        user_rst = 1'b0;
        trig = 1'b1;
        nwr = 0;
        for (int i = 0; i < 4; i++) tick();
        chk("noarm_nwr", nwr, 0);
        trig = 1'b0;
        ctrl_in = 32'h7;
        for (int i = 0; i < 20 && nwr < 9; i++) begin
            din = 32'h3000 + 32'(i);
            tick();
        end
        chk("rst_pre", nwr, 9);
        user_rst = 1'b1;
        ctrl_in = 32'h0;
        tick();
        chk("rst_status", status_out, 32'h0);
        user_rst = 1'b0;
        nwr = 0;
        for (int i = 0; i < 5; i++) tick();
        chk("rst_nwr", nwr, 0);

        // Random traffic
        for (int r = 0; r < 20; r++) begin
            ctrl_in = {29'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), 1'b0};
            trig_offset = 32'($urandom_range(0, 20));
            tick();
            ctrl_in[0] = 1'b1;
            for (int i = 0; i < 60; i++) begin
                we   = ($urandom_range(0, 3) != 0);
                trig = ($urandom_range(0, 7) == 0);
                din  = $urandom;
                if ($urandom_range(0, 5) == 0) trig_offset = 32'($urandom_range(0, 20));
                if ($urandom_range(0, 99) == 0) ctrl_in[0] = ~ctrl_in[0];
                user_rst = ($urandom_range(0, 199) == 0);
                tick();
            end
            user_rst = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
